// File: rtl/nx_stream_combiner.sv
// nx_stream_combiner: round-robin merge of the ctrl/mesh nexus streams into one host FIFO.
// Optional per-source message counters are compiled in with NX_STREAM_COMBINER_COUNT_EN.
package nx_pkg;
  typedef struct packed {
    logic [3:0]  kind;
    logic [27:0] payload;
  } nx_message_t;
endpackage

module nx_stream_combiner
  import nx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  nx_message_t            ctrl_ib_data_i,
  input  logic                   ctrl_ib_valid_i,
  output logic                   ctrl_ib_ready_o,
  input  nx_message_t            mesh_ib_data_i,
  input  logic                   mesh_ib_valid_i,
  output logic                   mesh_ib_ready_o,
  output nx_message_t            host_data_o,
  output logic                   host_src_o,
  output logic                   host_valid_o,
  input  logic                   host_ready_i,
  output logic                   idle_o,
  output logic [COUNT_WIDTH-1:0] ctrl_count_o,
  output logic [COUNT_WIDTH-1:0] mesh_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic        src;
    nx_message_t msg;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          run;
  logic          last_mesh;
  logic          empty;
  logic          full;
  logic          can_take;
  logic          ctrl_acc;
  logic          mesh_acc;
  logic          push;
  logic          pop;
  nx_message_t   push_data;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  // run gates readies until the first edge after reset release
  assign can_take = run & ~full;

  assign ctrl_ib_ready_o = can_take & (~mesh_ib_valid_i | last_mesh);
  assign mesh_ib_ready_o = can_take & (~ctrl_ib_valid_i | ~last_mesh);

  assign ctrl_acc  = ctrl_ib_valid_i & ctrl_ib_ready_o;
  assign mesh_acc  = mesh_ib_valid_i & mesh_ib_ready_o;
  assign push      = ctrl_acc | mesh_acc;
  assign pop       = ~empty & host_ready_i;
  assign push_data = mesh_acc ? mesh_ib_data_i : ctrl_ib_data_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      run       <= 1'b0;
      last_mesh <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      run <= 1'b1;
      if (push) begin
        last_mesh <= mesh_acc;
        wr_ptr    <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{src: mesh_acc, msg: push_data};
    end
  end

  assign host_valid_o = ~empty;
  assign host_data_o  = mem[rd_ptr].msg;
  assign host_src_o   = mem[rd_ptr].src;
  assign idle_o       = empty & ~ctrl_ib_valid_i & ~mesh_ib_valid_i;

`ifdef NX_STREAM_COMBINER_COUNT_EN
  logic [COUNT_WIDTH-1:0] ctrl_cnt;
  logic [COUNT_WIDTH-1:0] mesh_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_cnt <= '0;
      mesh_cnt <= '0;
    end else begin
      if (ctrl_acc && ctrl_cnt != '1) begin
        ctrl_cnt <= ctrl_cnt + COUNT_WIDTH'(1);
      end
      if (mesh_acc && mesh_cnt != '1) begin
        mesh_cnt <= mesh_cnt + COUNT_WIDTH'(1);
      end
    end
  end

  assign ctrl_count_o = ctrl_cnt;
  assign mesh_count_o = mesh_cnt;
`else
  assign ctrl_count_o = '0;
  assign mesh_count_o = '0;
`endif

endmodule
